// File: rtl/codec_init_sequencer.sv
// Walks a constant table of {addr,data} entries, writing each to the codec through the I2C controller.
// Optionally reads every entry back to verify it, retries failed entries, and reports done or error.
module codec_init_sequencer #(
    parameter int NUM_REGS       = 4,
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 8,
    parameter logic [NUM_REGS*(ADDR_W+DATA_W)-1:0] INIT_TABLE = '0,
    parameter int VERIFY         = 1,
    parameter int MAX_RETRIES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int AUTO_START     = 1,
    localparam int IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              codec_wr_en,
    output logic              codec_rd_en,
    output logic [ADDR_W-1:0] codec_reg_addr,
    output logic [DATA_W-1:0] codec_data_out,
    input  logic [DATA_W-1:0] codec_data_in,
    input  logic              codec_data_in_valid,
    input  logic              controller_busy,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_error,
    output logic [IDX_W-1:0]  err_index
);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, NEXT, DONE, ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         retry_q, retry_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               seen_q, seen_d;
    logic [IDX_W-1:0]   err_d;
    logic               auto_q;
    logic               fail;

    logic [ENT_W-1:0]   table_mem [NUM_REGS];
    logic [ADDR_W-1:0]  ent_addr;
    logic [DATA_W-1:0]  ent_data;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_tbl
        assign table_mem[g] = INIT_TABLE[g*ENT_W +: ENT_W];
    end

    assign ent_addr = table_mem[idx_q][ENT_W-1:DATA_W];
    assign ent_data = table_mem[idx_q][DATA_W-1:0];

    assign init_busy  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    assign init_done  = (state_q == DONE);
    assign init_error = (state_q == ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            wait_q    <= '0;
            seen_q    <= 1'b0;
            err_index <= '0;
            auto_q    <= 1'(AUTO_START);
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            wait_q    <= wait_d;
            seen_q    <= seen_d;
            err_index <= err_d;
            // Auto-start request only lives for the first cycle after reset release.
            auto_q    <= 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        retry_d        = retry_q;
        wait_d         = wait_q;
        seen_d         = seen_q;
        err_d          = err_index;
        fail           = 1'b0;
        codec_wr_en    = 1'b0;
        codec_rd_en    = 1'b0;
        codec_reg_addr = '0;
        codec_data_out = '0;

        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d = ISSUE_WR;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            ISSUE_WR: begin
                codec_reg_addr = ent_addr;
                codec_data_out = ent_data;
                if (!controller_busy) begin
                    codec_wr_en = 1'b1;
                    state_d     = WAIT_WR;
                    wait_d      = '0;
                    seen_d      = 1'b0;
                end
            end
            WAIT_WR: begin
                wait_d = wait_q + 1'b1;
                if (controller_busy) seen_d = 1'b1;
                // A write only counts as finished once busy has risen and fallen again.
                if (seen_q && !controller_busy) state_d = (VERIFY != 0) ? ISSUE_RD : NEXT;
                else if (wait_q == CNT_W'(TIMEOUT_CYCLES - 1)) fail = 1'b1;
            end
            ISSUE_RD: begin
                codec_reg_addr = ent_addr;
                codec_data_out = ent_data;
                if (!controller_busy) begin
                    codec_rd_en = 1'b1;
                    state_d     = WAIT_RD;
                    wait_d      = '0;
                end
            end
            WAIT_RD: begin
                wait_d = wait_q + 1'b1;
                if (codec_data_in_valid) begin
                    if (codec_data_in == ent_data) state_d = NEXT;
                    else fail = 1'b1;
                end else if (wait_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end
            end
            NEXT: begin
                retry_d = '0;
                if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ISSUE_WR;
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_d = ISSUE_WR;
                    idx_d   = '0;
                    retry_d = '0;
                    err_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            if (retry_q < 4'(MAX_RETRIES)) begin
                retry_d = retry_q + 1'b1;
                state_d = ISSUE_WR;
            end else begin
                err_d   = idx_q;
                state_d = ERROR;
            end
        end
    end
endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench: u0 (verify on, 16-cycle timeout) behind a scripted controller model, u1 (write only).
module tb_codec_init_sequencer;
    localparam logic [67:0] TBL = {9'h005, 8'h00, 9'h004, 8'h12, 9'h001, 8'h17, 9'h000, 8'h17};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // u0 signals
    logic       rst0, start0;
    logic       c0_wr, c0_rd, c0_bsy, c0_done, c0_error;
    logic [8:0] c0_addr;
    logic [7:0] c0_dout;
    logic [1:0] c0_eidx;
    logic       c0_busy = 1'b0;
    logic       c0_valid = 1'b0;
    logic [7:0] c0_din = 8'h00;

    // u1 signals
    logic       rst1, start1;
    logic       c1_wr, c1_rd, c1_bsy, c1_done, c1_error;
    logic [8:0] c1_addr;
    logic [7:0] c1_dout;
    logic [1:0] c1_eidx;
    logic       c1_busy = 1'b0;
    logic       c1_valid;
    logic [7:0] c1_din;

    codec_init_sequencer #(.INIT_TABLE(TBL), .TIMEOUT_CYCLES(16)) u0 (
        .clk(clk), .reset(rst0), .start(start0),
        .codec_wr_en(c0_wr), .codec_rd_en(c0_rd), .codec_reg_addr(c0_addr),
        .codec_data_out(c0_dout), .codec_data_in(c0_din), .codec_data_in_valid(c0_valid),
        .controller_busy(c0_busy), .init_busy(c0_bsy), .init_done(c0_done),
        .init_error(c0_error), .err_index(c0_eidx)
    );

    codec_init_sequencer #(.INIT_TABLE(TBL), .VERIFY(0)) u1 (
        .clk(clk), .reset(rst1), .start(start1),
        .codec_wr_en(c1_wr), .codec_rd_en(c1_rd), .codec_reg_addr(c1_addr),
        .codec_data_out(c1_dout), .codec_data_in(c1_din), .codec_data_in_valid(c1_valid),
        .controller_busy(c1_busy), .init_busy(c1_bsy), .init_done(c1_done),
        .init_error(c1_error), .err_index(c1_eidx)
    );

    // Strobe logs: bit 9 = read, bits 8:0 = address.
    logic [9:0] log0[$];
    int         stamp0[$];
    logic [9:0] log1[$];
    int         rd1_cnt = 0;

    // Model mode: 0 echo, 1 bad first readback of addr 1, 2 always bad at addr 4, 3 dead.
    int         mode = 0;
    logic [7:0] mem [512];
    int         bcnt0 = 0;
    logic       rd_pend0 = 1'b0;
    logic [7:0] rd_val0 = 8'h00;
    int         bcnt1 = 0;

    function automatic logic [7:0] exp_data(input logic [8:0] a);
        case (a)
            9'h000, 9'h001: return 8'h17;
            9'h004:         return 8'h12;
            9'h005:         return 8'h00;
            default:        return 8'hEE;
        endcase
    endfunction

    function automatic int count_log0(input logic [9:0] v);
        int n = 0;
        foreach (log0[i]) if (log0[i] == v) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log0(input string tag, input logic [9:0] exp[$]);
        check({tag, "_len"}, log0.size(), exp.size());
        foreach (exp[i]) if (i < log0.size()) check($sformatf("%s_%0d", tag, i), log0[i], exp[i]);
    endtask

    always @(posedge clk) begin
        c0_valid <= 1'b0;
        if (bcnt0 > 0) begin
            bcnt0 <= bcnt0 - 1;
            if (bcnt0 == 1) begin
                c0_busy <= 1'b0;
                if (rd_pend0) begin
                    c0_valid <= 1'b1;
                    c0_din   <= rd_val0;
                    rd_pend0 <= 1'b0;
                end
            end
        end
        if ((c0_wr || c0_rd) && mode != 3) begin
            c0_busy <= 1'b1;
            bcnt0   <= 3;
        end
        if (c0_wr && mode != 3) mem[c0_addr] <= c0_dout;
        if (c0_rd && mode != 3) begin
            rd_pend0 <= 1'b1;
            rd_val0  <= mem[c0_addr];
            if (mode == 1 && c0_addr == 9'h001 && count_log0(10'h201) == 1) rd_val0 <= 8'h97;
            if (mode == 2 && c0_addr == 9'h004) rd_val0 <= ~mem[c0_addr];
        end
    end

    always @(posedge clk) begin
        if (bcnt1 > 0) begin
            bcnt1 <= bcnt1 - 1;
            if (bcnt1 == 1) c1_busy <= 1'b0;
        end
        if (c1_wr || c1_rd) begin
            c1_busy <= 1'b1;
            bcnt1   <= 3;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (c0_wr) begin
            log0.push_back({1'b0, c0_addr});
            stamp0.push_back(cyc);
            check("wr0_data", c0_dout, exp_data(c0_addr));
        end
        if (c0_rd) log0.push_back({1'b1, c0_addr});
        if (c0_wr || c0_rd) check("strobe0_rules", {c0_wr & c0_rd, c0_busy}, 2'b00);
        if (c0_done || c0_error) check("done_err_excl0", c0_done & c0_error, 1'b0);
        if (c1_wr) begin
            log1.push_back({1'b0, c1_addr});
            check("wr1_data", c1_dout, exp_data(c1_addr));
        end
        if (c1_rd) rd1_cnt++;
        if (c1_wr || c1_rd) check("strobe1_rules", {c1_wr & c1_rd, c1_busy}, 2'b00);
    end

    task automatic wait_end0(input string tag);
        int n = 0;
        while (!(c0_done || c0_error) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_completes"}, c0_done | c0_error, 1'b1);
    endtask

    task automatic wait_end1(input string tag);
        int n = 0;
        while (!(c1_done || c1_error) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_completes"}, c1_done | c1_error, 1'b1);
    endtask

    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    initial begin
        int found;
        rst0 = 1'b1; start0 = 1'b0;
        rst1 = 1'b1; start1 = 1'b0;
        c1_valid = 1'b0; c1_din = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_outputs", {c0_wr, c0_rd, c0_addr, c0_dout, c0_bsy, c0_done, c0_error, c0_eidx}, '0);

        // Scenario 1: clean run after auto-start
        rst0 = 1'b0;
        #1 check("release_no_strobe", {c0_wr, c0_rd, c0_bsy}, 3'b000);
        wait_end0("s1");
        check("s1_flags", {c0_done, c0_error, c0_bsy}, 3'b100);
        check_log0("s1_log", '{10'h000, 10'h200, 10'h001, 10'h201, 10'h004, 10'h204, 10'h005, 10'h205});

        // Scenario 2: one bad readback of idx 1
        mode = 1;
        log0.delete(); stamp0.delete();
        pulse_start0();
        check("s2_restart", {c0_done, c0_bsy}, 2'b01);
        wait_end0("s2");
        check("s2_flags", {c0_done, c0_error}, 2'b10);
        check_log0("s2_log", '{10'h000, 10'h200, 10'h001, 10'h201, 10'h001, 10'h201,
                               10'h004, 10'h204, 10'h005, 10'h205});

        // Scenario 3: idx 2 always mismatches
        mode = 2;
        log0.delete(); stamp0.delete();
        pulse_start0();
        wait_end0("s3");
        check("s3_flags", {c0_done, c0_error, c0_bsy}, 3'b010);
        check("s3_err_index", c0_eidx, 2'd2);
        check("s3_wr_addr4", count_log0(10'h004), 3);
        check("s3_no_addr5", count_log0(10'h005) + count_log0(10'h205), 0);
        check_log0("s3_log", '{10'h000, 10'h200, 10'h001, 10'h201, 10'h004, 10'h204,
                               10'h004, 10'h204, 10'h004, 10'h204});

        // Scenario 4: controller never responds -> timeouts
        mode = 3;
        log0.delete(); stamp0.delete();
        pulse_start0();
        check("s4_cleared", {c0_error, c0_eidx, c0_bsy}, 4'b0001);
        wait_end0("s4");
        check("s4_flags", {c0_done, c0_error}, 2'b01);
        check("s4_err_index", c0_eidx, 2'd0);
        check_log0("s4_log", '{10'h000, 10'h000, 10'h000});
        if (stamp0.size() == 3) begin
            check("s4_gap1", stamp0[1] - stamp0[0], 17);
            check("s4_gap2", stamp0[2] - stamp0[1], 17);
        end

        // Scenario 5: reset in WAIT_RD of idx 1
        mode = 0;
        log0.delete(); stamp0.delete();
        pulse_start0();
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            @(negedge clk);
            if (c0_rd && c0_addr == 9'h001) found = 1;
        end
        check("s5_reached_rd1", found, 1);
        @(posedge clk);
        #1 rst0 = 1'b1;
        #1 check("s5_rst_outputs", {c0_wr, c0_rd, c0_addr, c0_dout, c0_bsy, c0_done, c0_error, c0_eidx}, '0);
        log0.delete(); stamp0.delete();
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        #1 check("s5_release_no_strobe", {c0_wr, c0_rd}, 2'b00);
        wait_end0("s5");
        check("s5_flags", {c0_done, c0_error}, 2'b10);
        check_log0("s5_log", '{10'h000, 10'h200, 10'h001, 10'h201, 10'h004, 10'h204, 10'h005, 10'h205});

        // Scenario 6: write-only instance, rerun from DONE, ignored mid-run start
        @(negedge clk);
        rst1 = 1'b0;
        wait_end1("s6a");
        check("s6a_flags", {c1_done, c1_error, c1_bsy}, 3'b100);
        check("s6a_writes", log1.size(), 4);
        check("s6a_no_reads", rd1_cnt, 0);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("s6b_restart", {c1_done, c1_bsy}, 2'b01);
        repeat (8) @(negedge clk);
        check("s6b_midrun", c1_bsy, 1'b1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_end1("s6b");
        check("s6b_flags", {c1_done, c1_error}, 2'b10);
        check("s6b_writes", log1.size(), 8);
        check("s6b_no_reads", rd1_cnt, 0);
        if (log1.size() == 8) begin
            check("s6b_order0", log1[4], 10'h000);
            check("s6b_order1", log1[5], 10'h001);
            check("s6b_order2", log1[6], 10'h004);
            check("s6b_order3", log1[7], 10'h005);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
